// File: rtl/link_if.sv
// Packet type and point-to-point link interface.
//
// link_pkg::packet_t is the payload carried on every link.
// link_if groups one link's wires:
//   packet  sender -> receiver  payload
//   req     sender -> receiver  payload is valid this cycle
//   ack     receiver -> sender  combinational accept; a transfer happens
//                               on any rising edge with req && ack
// The sender modport drives packet/req, and the receiver modport drives ack.

package link_pkg;
    typedef logic [7:0] packet_t;
endpackage

interface link_if;
    import link_pkg::*;

    packet_t packet;
    logic    req;
    logic    ack;

    modport sender   (output packet, output req, input  ack);
    modport receiver (input  packet, input  req, output ack);
endinterface

// File: rtl/link_arbiter.sv
// link_arbiter: round-robin N-to-1 merge stage with a single-entry output
// register.
//
// Ports:
//   clock        positive-edge clock
//   reset_n      asynchronous active-low reset
//   enable       when low, state holds and every ack and req is 0
//   quiescent    high while the output register is empty
//   input_links  NUM_INPUTS upstream links (this block drives ack)
//   output_link  downstream link (this block drives packet and req)
//
// One input is granted per cycle. The search starts at prio_q and wraps.
// After a completed input transfer the priority moves to the input just
// past the winner, with an explicit wrap so that non-power-of-two counts
// stay in range.

module link_arbiter #(
    parameter int NUM_INPUTS = 4
) (
    input  logic    clock,
    input  logic    reset_n,
    input  logic    enable,
    output logic    quiescent,
    link_if.receiver input_links [NUM_INPUTS],
    link_if.sender   output_link
);
    import link_pkg::*;

    localparam int IDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

    // Output register and priority pointer
    logic             out_valid_q, out_valid_d;
    packet_t          out_packet_q, out_packet_d;
    logic [IDX_W-1:0] prio_q, prio_d;

    // Flattened copies of the interface array (the array needs constant indices)
    logic    [NUM_INPUTS-1:0] req_vec;
    packet_t                  pkt_arr [NUM_INPUTS];

    logic             drain;
    logic             can_load;
    logic             load;
    logic             grant_valid;
    logic [IDX_W-1:0] grant_idx;
    logic [IDX_W:0]   cand;

    generate
        for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_in
            assign req_vec[gi]         = input_links[gi].req;
            assign pkt_arr[gi]         = input_links[gi].packet;
            assign input_links[gi].ack = load && (grant_idx == IDX_W'(gi));
        end
    endgenerate

    assign drain = enable && out_valid_q && output_link.ack;
    // reset_n gates loading so that no upstream link is acked while reset is held.
    assign can_load = reset_n && enable && (!out_valid_q || drain);
    assign load     = can_load && grant_valid;

    // Rotating first-match search: prio_q, prio_q+1, ... wrapping at NUM_INPUTS.
    // cand has one extra bit so that the sum cannot overflow before the wrap.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            cand = {1'b0, prio_q} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(NUM_INPUTS))
                cand = cand - (IDX_W+1)'(NUM_INPUTS);
            if (!grant_valid && req_vec[cand[IDX_W-1:0]]) begin
                grant_valid = 1'b1;
                grant_idx   = cand[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        out_valid_d  = out_valid_q;
        out_packet_d = out_packet_q;
        prio_d       = prio_q;
        if (load) begin
            // A load also covers drain-plus-load: the register stays full.
            out_valid_d  = 1'b1;
            out_packet_d = pkt_arr[grant_idx];
            prio_d       = (grant_idx == IDX_W'(NUM_INPUTS - 1)) ? '0 : grant_idx + 1'b1;
        end else if (drain) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q  <= 1'b0;
            out_packet_q <= '0;
            prio_q       <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_packet_q <= out_packet_d;
            prio_q       <= prio_d;
        end
    end

    // Both downstream signals come straight from the register.
    assign output_link.req    = enable && out_valid_q;
    assign output_link.packet = out_packet_q;
    assign quiescent          = !out_valid_q;

endmodule

// File: tb/tb_link_arbiter.sv
// Directed testbench for link_arbiter. It drives a 4-input instance and a
// 3-input instance, and every comparison is an immediate assertion against a
// hand-computed value.

module tb_link_arbiter;
    import link_pkg::*;

    logic clock = 1'b0;
    logic reset_n;
    logic enable;

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // 4-input instance
    logic    [3:0] a_req;
    packet_t       a_pkt [4];
    logic    [3:0] a_ack;
    logic          a_out_ack;
    logic          a_quiescent;

    link_if a_in [4] ();
    link_if a_out ();

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_a
            assign a_in[gi].req    = a_req[gi];
            assign a_in[gi].packet = a_pkt[gi];
            assign a_ack[gi]       = a_in[gi].ack;
        end
    endgenerate
    assign a_out.ack = a_out_ack;

    link_arbiter #(.NUM_INPUTS(4)) dut_a (
        .clock       (clock),
        .reset_n     (reset_n),
        .enable      (enable),
        .quiescent   (a_quiescent),
        .input_links (a_in),
        .output_link (a_out)
    );

    // 3-input instance (non-power-of-two wrap)
    logic    [2:0] b_req;
    packet_t       b_pkt [3];
    logic    [2:0] b_ack;
    logic          b_out_ack;
    logic          b_quiescent;

    link_if b_in [3] ();
    link_if b_out ();

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_b
            assign b_in[gi].req    = b_req[gi];
            assign b_in[gi].packet = b_pkt[gi];
            assign b_ack[gi]       = b_in[gi].ack;
        end
    endgenerate
    assign b_out.ack = b_out_ack;

    link_arbiter #(.NUM_INPUTS(3)) dut_b (
        .clock       (clock),
        .reset_n     (reset_n),
        .enable      (enable),
        .quiescent   (b_quiescent),
        .input_links (b_in),
        .output_link (b_out)
    );

    // One line per completed downstream transfer
    always @(posedge clock) begin
        if (a_out.req && a_out.ack) $display("[%0t] A out xfer packet=%h", $time, a_out.packet);
        if (b_out.req && b_out.ack) $display("[%0t] B out xfer packet=%h", $time, b_out.packet);
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    int ack_cnt [4];
    int g;

    initial begin
        reset_n   = 1'b0;
        enable    = 1'b1;
        a_req     = '0;
        b_req     = '0;
        a_out_ack = 1'b1;
        b_out_ack = 1'b1;
        for (int i = 0; i < 4; i++) a_pkt[i] = '0;
        for (int i = 0; i < 3; i++) b_pkt[i] = '0;

        // Reset state, with every input requesting so that the zero acks mean something
        #2;
        a_req = 4'hF;
        #1;
        check("rst_out_req", a_out.req, 1'b0);
        check("rst_quiescent", a_quiescent, 1'b1);
        check("rst_out_packet", a_out.packet, 8'h00);
        check("rst_acks", a_ack, 4'h0);
        a_req = '0;
        @(negedge clock);
        reset_n = 1'b1;
        step();

        // Single input 2 streaming 0x11, 0x22, 0x33 with the downstream always acking
        a_req    = 4'b0100;
        a_pkt[2] = 8'h11;
        #1;
        check("single_ack0", a_ack, 4'b0100);
        check("single_req0", a_out.req, 1'b0);
        step();
        a_pkt[2] = 8'h22;
        #1;
        check("single_pkt1", a_out.packet, 8'h11);
        check("single_req1", a_out.req, 1'b1);
        check("single_ack1", a_ack, 4'b0100);
        step();
        a_pkt[2] = 8'h33;
        #1;
        check("single_pkt2", a_out.packet, 8'h22);
        check("single_ack2", a_ack, 4'b0100);
        step();
        a_req = '0;
        #1;
        check("single_pkt3", a_out.packet, 8'h33);
        check("single_req3", a_out.req, 1'b1);
        check("single_ack3", a_ack, 4'b0000);
        step();
        check("single_empty", a_quiescent, 1'b1);

        // Asynchronous reset in mid-cycle while a packet is held
        a_pkt[1]  = 8'hA1;
        a_req     = 4'b0010;
        a_out_ack = 1'b0;
        step();
        a_req = '0;
        #1;
        check("midrst_held_req", a_out.req, 1'b1);
        check("midrst_held_pkt", a_out.packet, 8'hA1);
        reset_n = 1'b0;
        #1;
        check("midrst_req", a_out.req, 1'b0);
        check("midrst_quiescent", a_quiescent, 1'b1);
        check("midrst_packet", a_out.packet, 8'h00);
        for (int i = 0; i < 4; i++) a_pkt[i] = 8'h40 + 8'(i);
        a_req     = 4'hF;
        a_out_ack = 1'b1;
        #1;
        check("midrst_acks", a_ack, 4'h0);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        check("post_rst_first_grant", a_ack, 4'b0001);

        // All four requesting with the downstream always acking: order 0,1,2,3,0,1,2,3
        for (int i = 0; i < 4; i++) ack_cnt[i] = 0;
        for (int c = 0; c < 8; c++) begin
            g = c % 4;
            check("rr_ack", a_ack, 4'b0001 << g);
            for (int i = 0; i < 4; i++) if (a_ack[i]) ack_cnt[i]++;
            step();
            check("rr_pkt", a_out.packet, 8'h40 + 8'(g));
            check("rr_req", a_out.req, 1'b1);
        end
        for (int i = 0; i < 4; i++) check("rr_fair_count", ack_cnt[i], 2);

        // Downstream stall with inputs 1 and 3 requesting (priority is back at 0)
        a_req = 4'b1010;
        #1;
        check("stall_pre_ack", a_ack, 4'b0010);
        step();
        a_out_ack = 1'b0;
        #1;
        for (int c = 0; c < 3; c++) begin
            check("stall_ack", a_ack, 4'b0000);
            check("stall_pkt", a_out.packet, 8'h41);
            check("stall_req", a_out.req, 1'b1);
            step();
        end
        a_out_ack = 1'b1;
        #1;
        check("stall_release_ack", a_ack, 4'b1000);
        step();
        check("stall_release_pkt", a_out.packet, 8'h43);
        a_req = '0;
        #1;
        check("stall_tail_ack", a_ack, 4'b0000);
        step();
        check("stall_empty", a_quiescent, 1'b1);

        // Enable low for two cycles with a held packet and the downstream acking
        a_pkt[2]  = 8'h5A;
        a_req     = 4'b0100;
        a_out_ack = 1'b0;
        step();
        a_req     = 4'b0001;
        a_out_ack = 1'b1;
        enable    = 1'b0;
        #1;
        check("en_low_req0", a_out.req, 1'b0);
        check("en_low_ack0", a_ack, 4'b0000);
        check("en_low_quiescent0", a_quiescent, 1'b0);
        step();
        check("en_low_req1", a_out.req, 1'b0);
        check("en_low_ack1", a_ack, 4'b0000);
        check("en_low_quiescent1", a_quiescent, 1'b0);
        step();
        a_req  = '0;
        enable = 1'b1;
        #1;
        check("en_back_req", a_out.req, 1'b1);
        check("en_back_pkt", a_out.packet, 8'h5A);
        step();
        check("en_back_drained", a_quiescent, 1'b1);

        // Three-input wrap: a grant to input 2 must move priority to 0
        b_pkt[0] = 8'hB0;
        b_pkt[1] = 8'hB1;
        b_pkt[2] = 8'hB2;
        b_req    = 3'b100;
        #1;
        check("wrap_ack2", b_ack, 3'b100);
        step();
        b_req = 3'b011;
        #1;
        check("wrap_pkt2", b_out.packet, 8'hB2);
        check("wrap_ack0", b_ack, 3'b001);
        step();
        b_req = '0;
        #1;
        check("wrap_pkt0", b_out.packet, 8'hB0);
        step();
        check("wrap_empty", b_quiescent, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/link_arbiter.md
# link_arbiter

Round-robin N-to-1 merge stage for the interconnect. It accepts packets from `NUM_INPUTS` upstream links, grants one per cycle, and holds the granted packet in a single-entry output register. That register drives one downstream link, normally the input side of a link buffer. It is the fan-in point wherever several producers (router ports, PE output channels) share one link.

## Interface
- `NUM_INPUTS`, default 4: number of upstream links; legal range 2..16, need not be a power of two.
- `clock`  input  1  positive-edge clock.
- `reset_n`  input  1  asynchronous, active-low reset.
- `enable`  input  1  active high; when low, no state changes and all acks/req are 0.
- `quiescent`  output  1  high when the output register is empty.
- `input_links[NUM_INPUTS]`  link_if.receiver  packet_t + req/ack  upstream links; this block drives `ack`.
- `output_link`  link_if.sender  packet_t + req/ack  downstream link; this block drives `packet` and `req`.

## Operation
- Link protocol: the sender drives `packet`/`req`, and the receiver drives `ack` combinationally. A transfer happens in any cycle with `req && ack` at the rising edge. `ack` is never asserted without `req`.
- State:
  - `out_valid` (1b) and `out_packet` (packet_t): the output register.
  - `priority` ($clog2(NUM_INPUTS)b): the highest-priority input index.
- `drain = enable && out_valid && output_link.ack`.
- `can_load = enable && (!out_valid || drain)`.
- Grant: the first input i with `input_links[i].req`, searching `priority, priority+1, …, NUM_INPUTS-1, 0, …, priority-1`.
- `input_links[g].ack = can_load && input_links[g].req` for the granted g only. Every other ack is 0.
- Load (a transfer on input g):
  - `out_packet <= input_links[g].packet`.
  - `out_valid <= 1`.
  - `priority <= (g == NUM_INPUTS-1) ? 0 : g+1`.
  - Wrap-around is explicit, so non-power-of-two counts never point at an index ≥ NUM_INPUTS.
- Drain with no load: `out_valid <= 0`.
- Drain and load in the same cycle: `out_valid` stays 1 and `out_packet` is replaced (pass-through at full rate).
- No grant: `priority` is unchanged. Priority advances only on a completed input transfer.
- `output_link.req = enable && out_valid`, and `output_link.packet = out_packet`.
- `quiescent = !out_valid`. It is independent of `enable`.
- Reset: `out_valid = 0`, `priority = 0`, `out_packet = 0`.
  - Reset outputs: `output_link.req = 0`, all input acks 0, `quiescent = 1`, `output_link.packet = 0`.
- Reset asserted mid-operation clears the held packet immediately (asynchronous). The packet is dropped; the upstream has already seen its ack.
- `enable` low: the register and priority hold, `output_link.req = 0` (no transfer can be lost), and all input acks are 0.

## Timing
- Latency: 1 cycle. A packet accepted at edge k appears on `output_link` with `req = 1` during cycle k+1.
- Throughput: 1 packet/cycle while downstream acks every cycle.
- Throughput with downstream stalled: 0. The register holds its packet and every input ack is 0 until the output transfer.
- Combinational paths:
  - `output_link.ack` → `input_links[*].ack`.
  - `input_links[*].req` → `input_links[*].ack`.
  - There is no path from any input to `output_link.req` or `output_link.packet`; both come from the register.
- Fairness: with all inputs continuously requesting, each input is granted exactly once per NUM_INPUTS consecutive loads.

## Test plan
- **Reset values**: `reset_n = 0` asynchronously mid-cycle with `out_valid = 1` → `output_link.req` drops before the next edge, `quiescent = 1`, all acks 0. After release, the first grant goes to input 0.
- **Single input, output always acks**: input 2 sends 0x11, 0x22, 0x33 on consecutive cycles → `output_link` carries 0x11, 0x22, 0x33 on cycles 1, 2, 3. `ack[2]` is high every cycle.
- **All 4 inputs requesting, output always acks**: grant order is 0, 1, 2, 3, 0, 1… Each input receives exactly 2 acks in 8 cycles.
- **Downstream stall**: with `out_valid = 1`, hold `output_link.ack = 0` for 3 cycles while inputs 1 and 3 request → no input ack and `output_link.packet` stable. On the first ack cycle exactly one input (per priority) is acked in the same cycle.
- **Non-power-of-two wrap**: NUM_INPUTS = 3, only input 2 then input 0 requesting → after a grant to 2, `priority` becomes 0 (not 3), and input 0 is granted next.
- **Enable low**: deassert `enable` for 2 cycles with a held packet and downstream ack = 1 → `output_link.req = 0`, the packet is retained, and it is delivered on the first cycle after `enable` returns.
